// File: rtl/ram_param_clr_pkg.sv
// Shared types and helpers for the parametrised clearing RAM.
// Holds the clear-sequencer state encoding and the depth helper.
package ram_param_clr_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } seq_state_t;

    function automatic int depth_of(input int addr_w);
        return 1 << addr_w;
    endfunction

endpackage

// File: rtl/ram_param_clr_seq.sv
// Clear sequencer: after reset walks every address once, driving a clear
// write each cycle, then drops busy and hands the array to the user ports.
module ram_param_clr_seq
    import ram_param_clr_pkg::*;
#(
    parameter int ADDR_W         = 5,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic              clk_i,
    input  logic              reset_i,
    output logic              busy_o,
    output logic              clr_we_o,
    output logic [ADDR_W-1:0] clr_addr_o
);

    // Depth is a power of two, so the last address is all ones.
    localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

    seq_state_t        r_state;
    seq_state_t        w_state_next;
    logic [ADDR_W-1:0] r_cnt;
    logic [ADDR_W-1:0] w_cnt_next;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        busy_o       = 1'b0;
        clr_we_o     = 1'b0;
        clr_addr_o   = r_cnt;
        case (r_state)
            ST_CLEAR: begin
                busy_o     = 1'b1;
                clr_we_o   = 1'b1;
                w_cnt_next = r_cnt + ADDR_W'(1);
                if (r_cnt == LAST_ADDR) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
            end
        endcase
    end

endmodule

// File: rtl/ram_param_clr.sv
// Parametrised synchronous RAM: lane-masked write port, NUM_RD registered
// read ports with optional write-to-read bypass, and a post-reset clear.
module ram_param_clr
    import ram_param_clr_pkg::*;
#(
    parameter int                DATA_W         = 16,
    parameter int                ADDR_W         = 5,
    parameter int                NUM_RD         = 2,
    parameter int                LANE_W         = 8,
    parameter int                BYPASS         = 1,
    parameter int                CLEAR_ON_RESET = 1,
    parameter logic [DATA_W-1:0] CLEAR_VALUE    = '0
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    output logic                     busy_o,
    input  logic                     wen_i,
    input  logic [ADDR_W-1:0]        waddr_i,
    input  logic [DATA_W-1:0]        wdata_i,
    input  logic [DATA_W/LANE_W-1:0] wmask_i,
    input  logic [NUM_RD-1:0]        ren_i,
    input  logic [NUM_RD*ADDR_W-1:0] raddr_i,
    output logic [NUM_RD*DATA_W-1:0] rdata_o
);

    localparam int DEPTH     = depth_of(ADDR_W);
    localparam int NUM_LANES = DATA_W / LANE_W;

    if ((DATA_W % LANE_W) != 0) begin : g_bad_lane_w
        $error("ram_param_clr: DATA_W must be a multiple of LANE_W");
    end
    if ((NUM_RD < 1) || (NUM_RD > 4)) begin : g_bad_num_rd
        $error("ram_param_clr: NUM_RD must be in 1..4");
    end

    logic                 w_busy;
    logic                 w_clr_we;
    logic [ADDR_W-1:0]    w_clr_addr;

    logic                 w_wr_en;
    logic [ADDR_W-1:0]    w_wr_addr;
    logic [DATA_W-1:0]    w_wr_data;
    logic [NUM_LANES-1:0] w_wr_lane;

    logic [DATA_W-1:0]    r_mem [DEPTH];
    logic [DATA_W-1:0]    r_rdata [NUM_RD];

    ram_param_clr_seq #(
        .ADDR_W         (ADDR_W),
        .CLEAR_ON_RESET (CLEAR_ON_RESET)
    ) u_seq (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .busy_o     (w_busy),
        .clr_we_o   (w_clr_we),
        .clr_addr_o (w_clr_addr)
    );

    assign busy_o = w_busy;

    // The clear walk owns the write port; user writes are dropped meanwhile.
    always_comb begin
        w_wr_en   = 1'b0;
        w_wr_addr = waddr_i;
        w_wr_data = wdata_i;
        w_wr_lane = wmask_i;
        if (w_clr_we) begin
            w_wr_en   = 1'b1;
            w_wr_addr = w_clr_addr;
            w_wr_data = CLEAR_VALUE;
            w_wr_lane = '1;
        end else begin
            w_wr_en = wen_i;
        end
        if (reset_i) begin
            w_wr_en = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_wr_en) begin
            for (int k = 0; k < NUM_LANES; k++) begin
                if (w_wr_lane[k]) begin
                    r_mem[w_wr_addr][k*LANE_W +: LANE_W] <= w_wr_data[k*LANE_W +: LANE_W];
                end
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
            logic [ADDR_W-1:0] w_raddr;
            logic [DATA_W-1:0] w_rd_val;

            assign w_raddr = raddr_i[gi*ADDR_W +: ADDR_W];

            // With bypass, lanes being written this edge come straight from wdata_i.
            always_comb begin
                w_rd_val = r_mem[w_raddr];
                if ((BYPASS != 0) && wen_i && (w_raddr == waddr_i)) begin
                    for (int k = 0; k < NUM_LANES; k++) begin
                        if (wmask_i[k]) begin
                            w_rd_val[k*LANE_W +: LANE_W] = wdata_i[k*LANE_W +: LANE_W];
                        end
                    end
                end
            end

            always_ff @(posedge clk_i) begin
                if (reset_i || w_busy) begin
                    r_rdata[gi] <= '0;
                end else if (ren_i[gi]) begin
                    r_rdata[gi] <= w_rd_val;
                end
            end

            assign rdata_o[gi*DATA_W +: DATA_W] = r_rdata[gi];
        end
    endgenerate

endmodule
